// File: rtl/wash_sequencer.sv
// Washing-machine sequencer: coin/lid/cancel FSM with phase timers, rinse repeat, lid pause, fault codes.
// All outputs registered (one cycle from the sampled inputs); no backpressure, every input is sampled each cycle.
module wash_sequencer #(
  parameter int CNT_W        = 8,
  parameter int FILL_TIMEOUT = 20,
  parameter int SOAK_TIME    = 3,
  parameter int WASH_TIME    = 5,
  parameter int RINSE_TIME   = 3,
  parameter int RINSE_CYCLES = 2,
  parameter int SPIN_TIME    = 3,
  parameter int DRY_TIME     = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_Coin,
  input  logic             sig_Lid_Closed,
  input  logic             sig_Cancel,
  input  logic             sig_Full,
  input  logic             sig_Out_Of_Balance,
  input  logic             sig_Motor_Failure,
  input  logic             sig_Fault_Clear,
  input  logic             skip_Dry,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] phase_Timer,
  output logic [3:0]       rinse_Count,
  output logic             water_Intake,
  output logic             motor_On,
  output logic             paused,
  output logic             coin_Return,
  output logic             fault,
  output logic [1:0]       fault_Code,
  output logic             cycle_Done
);

  typedef enum logic [3:0] {
    S_START = 4'd0,
    S_READY = 4'd1,
    S_FILL  = 4'd2,
    S_SOAK  = 4'd3,
    S_WASH  = 4'd4,
    S_RINSE = 4'd5,
    S_SPIN  = 4'd6,
    S_DRY   = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SOAK_LAST  = CNT_W'(SOAK_TIME - 1);
  localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_TIME - 1);
  localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_TIME - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_TIME - 1);
  localparam logic [CNT_W-1:0] DRY_LAST   = CNT_W'(DRY_TIME - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       RINSE_PASSES = 4'(RINSE_CYCLES);

  state_t           cur_st;
  state_t           nxt_st;
  logic [CNT_W-1:0] timer_nxt;
  logic [3:0]       rinse_nxt;
  logic [1:0]       code_nxt;
  logic             skip_lat;
  logic             skip_nxt;
  logic             water_nxt;
  logic             motor_nxt;
  logic             paused_nxt;
  logic             coin_ret_nxt;
  logic             fault_nxt;
  logic             done_nxt;

  logic             active;
  logic             hold;
  logic             restart;
  logic             phase_end;
  logic             fault_hit;
  logic [1:0]       fault_val;

  assign state = cur_st;

  // Per-phase completion and fault detection, independent of priority resolution.
  always_comb begin
    phase_end = 1'b0;
    fault_hit = 1'b0;
    fault_val = 2'd0;
    case (cur_st)
      S_FILL: begin
        phase_end = sig_Full;
        if (!sig_Full && phase_Timer == FILL_LAST) begin
          fault_hit = 1'b1;
          fault_val = 2'd1;
        end
      end
      S_SOAK: phase_end = (phase_Timer == SOAK_LAST);
      S_WASH: begin
        phase_end = (phase_Timer == WASH_LAST);
        if (sig_Out_Of_Balance) begin
          fault_hit = 1'b1;
          fault_val = 2'd2;
        end
      end
      S_RINSE: begin
        phase_end = (phase_Timer == RINSE_LAST);
        if (sig_Motor_Failure) begin
          fault_hit = 1'b1;
          fault_val = 2'd3;
        end
      end
      S_SPIN, S_DRY: begin
        phase_end = (cur_st == S_SPIN) ? (phase_Timer == SPIN_LAST)
                                       : (phase_Timer == DRY_LAST);
        if (sig_Motor_Failure) begin
          fault_hit = 1'b1;
          fault_val = 2'd3;
        end else if (sig_Out_Of_Balance) begin
          fault_hit = 1'b1;
          fault_val = 2'd2;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt_st       = cur_st;
    rinse_nxt    = rinse_Count;
    code_nxt     = fault_Code;
    skip_nxt     = skip_lat;
    coin_ret_nxt = 1'b0;
    done_nxt     = 1'b0;
    hold         = 1'b0;
    restart      = 1'b0;
    active       = (cur_st inside {S_FILL, S_SOAK, S_WASH, S_RINSE, S_SPIN, S_DRY});

    case (cur_st)
      S_START: if (sig_Coin) nxt_st = S_READY;
      S_READY: begin
        if (sig_Cancel) begin
          nxt_st       = S_START;
          coin_ret_nxt = 1'b1;
        end else if (sig_Lid_Closed) begin
          // New cycle: latch the dry mode and drop stale per-cycle status.
          nxt_st    = S_FILL;
          skip_nxt  = skip_Dry;
          code_nxt  = 2'd0;
          rinse_nxt = 4'd0;
        end
      end
      S_FAULT: begin
        if (sig_Fault_Clear) begin
          nxt_st    = S_READY;
          rinse_nxt = 4'd0;
        end
      end
      S_FILL, S_SOAK, S_WASH, S_RINSE, S_SPIN, S_DRY: ;
      default: nxt_st = S_START;
    endcase

    if (active) begin
      if (sig_Cancel) begin
        nxt_st       = S_START;
        coin_ret_nxt = 1'b1;
        rinse_nxt    = 4'd0;
      end else if (fault_hit) begin
        nxt_st   = S_FAULT;
        code_nxt = fault_val;
      end else if (!sig_Lid_Closed) begin
        hold = 1'b1;
      end else if (phase_end) begin
        case (cur_st)
          S_FILL: nxt_st = S_SOAK;
          S_SOAK: nxt_st = S_WASH;
          S_WASH: nxt_st = S_RINSE;
          S_RINSE: begin
            rinse_nxt = rinse_Count + 4'd1;
            if (rinse_nxt < RINSE_PASSES) restart = 1'b1;
            else                          nxt_st  = S_SPIN;
          end
          S_SPIN: begin
            if (skip_lat) begin
              nxt_st   = S_START;
              done_nxt = 1'b1;
            end else begin
              nxt_st = S_DRY;
            end
          end
          S_DRY: begin
            nxt_st   = S_START;
            done_nxt = 1'b1;
          end
          default: ;
        endcase
      end
    end

    // A repeated rinse pass restarts the timer even though the state is unchanged.
    if (nxt_st != cur_st || restart) timer_nxt = '0;
    else if (hold || phase_Timer == TIMER_MAX) timer_nxt = phase_Timer;
    else timer_nxt = phase_Timer + CNT_W'(1);

    water_nxt  = (nxt_st == S_FILL || nxt_st == S_RINSE) && !hold;
    motor_nxt  = (nxt_st inside {S_WASH, S_RINSE, S_SPIN, S_DRY}) && !hold;
    paused_nxt = hold;
    fault_nxt  = (nxt_st == S_FAULT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_st       <= S_START;
      phase_Timer  <= '0;
      rinse_Count  <= 4'd0;
      fault_Code   <= 2'd0;
      skip_lat     <= 1'b0;
      water_Intake <= 1'b0;
      motor_On     <= 1'b0;
      paused       <= 1'b0;
      coin_Return  <= 1'b0;
      fault        <= 1'b0;
      cycle_Done   <= 1'b0;
    end else begin
      cur_st       <= nxt_st;
      phase_Timer  <= timer_nxt;
      rinse_Count  <= rinse_nxt;
      fault_Code   <= code_nxt;
      skip_lat     <= skip_nxt;
      water_Intake <= water_nxt;
      motor_On     <= motor_nxt;
      paused       <= paused_nxt;
      coin_Return  <= coin_ret_nxt;
      fault        <= fault_nxt;
      cycle_Done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: expectations are queued with each step and checked after the clock edge.
module tb_wash_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       sig_Coin, sig_Lid_Closed, sig_Cancel, sig_Full;
  logic       sig_Out_Of_Balance, sig_Motor_Failure, sig_Fault_Clear, skip_Dry;
  logic [3:0] state;
  logic [7:0] phase_Timer;
  logic [3:0] rinse_Count;
  logic       water_Intake, motor_On, paused, coin_Return, fault, cycle_Done;
  logic [1:0] fault_Code;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  wash_sequencer dut (
    .clock              (clock),
    .reset              (reset),
    .sig_Coin           (sig_Coin),
    .sig_Lid_Closed     (sig_Lid_Closed),
    .sig_Cancel         (sig_Cancel),
    .sig_Full           (sig_Full),
    .sig_Out_Of_Balance (sig_Out_Of_Balance),
    .sig_Motor_Failure  (sig_Motor_Failure),
    .sig_Fault_Clear    (sig_Fault_Clear),
    .skip_Dry           (skip_Dry),
    .state              (state),
    .phase_Timer        (phase_Timer),
    .rinse_Count        (rinse_Count),
    .water_Intake       (water_Intake),
    .motor_On           (motor_On),
    .paused             (paused),
    .coin_Return        (coin_Return),
    .fault              (fault),
    .fault_Code         (fault_Code),
    .cycle_Done         (cycle_Done)
  );

  typedef enum int {O_STATE, O_TIMER, O_RINSE, O_WATER, O_MOTOR,
                    O_PAUSED, O_CRET, O_FAULT, O_CODE, O_DONE} osel_t;
  typedef struct {
    string       tag;
    osel_t       sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] observe(osel_t s);
    case (s)
      O_STATE:  return 32'(state);
      O_TIMER:  return 32'(phase_Timer);
      O_RINSE:  return 32'(rinse_Count);
      O_WATER:  return 32'(water_Intake);
      O_MOTOR:  return 32'(motor_On);
      O_PAUSED: return 32'(paused);
      O_CRET:   return 32'(coin_Return);
      O_FAULT:  return 32'(fault);
      O_CODE:   return 32'(fault_Code);
      default:  return 32'(cycle_Done);
    endcase
  endfunction

  task automatic exp_o(input string tag, input osel_t s, input int v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = 32'(v);
    sb.push_back(e);
  endtask

  task automatic exp_st(input string tag, input int st, input int tmr);
    exp_o({tag, ".state"}, O_STATE, st);
    exp_o({tag, ".timer"}, O_TIMER, tmr);
  endtask

  task automatic check_q();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    check_q();
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {sig_Coin, sig_Lid_Closed, sig_Cancel, sig_Full} = '0;
    {sig_Out_Of_Balance, sig_Motor_Failure, sig_Fault_Clear, skip_Dry} = '0;

    // Reset state
    #12;
    exp_st("rst", 0, 0);
    exp_o("rst.rinse", O_RINSE, 0);  exp_o("rst.water", O_WATER, 0);
    exp_o("rst.motor", O_MOTOR, 0);  exp_o("rst.paused", O_PAUSED, 0);
    exp_o("rst.cret", O_CRET, 0);    exp_o("rst.fault", O_FAULT, 0);
    exp_o("rst.code", O_CODE, 0);    exp_o("rst.done", O_DONE, 0);
    check_q();
    @(negedge clock);
    reset = 1'b0;

    // Normal run with defaults
    sig_Coin = 1'b1; sig_Lid_Closed = 1'b1;
    exp_o("run.ready", O_STATE, 1); tick();
    sig_Coin = 1'b0;
    exp_st("run.fill", 2, 0); exp_o("run.fill.water", O_WATER, 1);
    exp_o("run.fill.motor", O_MOTOR, 0); tick();
    exp_st("run.fill1", 2, 1); tick();
    exp_st("run.fill2", 2, 2); tick();
    sig_Full = 1'b1;
    exp_st("run.soak", 3, 0); exp_o("run.soak.water", O_WATER, 0); tick();
    sig_Full = 1'b0;
    for (int i = 1; i < 3; i++) begin exp_st("run.soak_n", 3, i); tick(); end
    exp_st("run.wash", 4, 0); exp_o("run.wash.motor", O_MOTOR, 1); tick();
    for (int i = 1; i < 5; i++) begin exp_st("run.wash_n", 4, i); tick(); end
    exp_st("run.rinse", 5, 0); exp_o("run.rinse.rc", O_RINSE, 0);
    exp_o("run.rinse.water", O_WATER, 1); tick();
    for (int i = 1; i < 3; i++) begin exp_st("run.rinse_a", 5, i); tick(); end
    exp_st("run.rinse2", 5, 0); exp_o("run.rinse2.rc", O_RINSE, 1); tick();
    for (int i = 1; i < 3; i++) begin exp_st("run.rinse_b", 5, i); tick(); end
    exp_st("run.spin", 6, 0); exp_o("run.spin.rc", O_RINSE, 2);
    exp_o("run.spin.water", O_WATER, 0); exp_o("run.spin.motor", O_MOTOR, 1); tick();
    for (int i = 1; i < 3; i++) begin exp_st("run.spin_n", 6, i); tick(); end
    exp_st("run.dry", 7, 0); tick();
    for (int i = 1; i < 3; i++) begin exp_st("run.dry_n", 7, i); tick(); end
    exp_st("run.end", 0, 0); exp_o("run.end.done", O_DONE, 1);
    exp_o("run.end.motor", O_MOTOR, 0); tick();
    exp_o("run.end.done_off", O_DONE, 0); exp_o("run.end.state", O_STATE, 0); tick();

    // Cancel from READY returns the coin
    sig_Lid_Closed = 1'b0; sig_Coin = 1'b1;
    exp_o("rcan.ready", O_STATE, 1); tick();
    sig_Coin = 1'b0; sig_Cancel = 1'b1;
    exp_o("rcan.state", O_STATE, 0); exp_o("rcan.cret", O_CRET, 1); tick();
    sig_Cancel = 1'b0;
    exp_o("rcan.cret_off", O_CRET, 0); tick();

    reset = 1'b1; tick(); reset = 1'b0;

    // skip_Dry latched on READY exit only
    sig_Coin = 1'b1;
    exp_o("skip.ready", O_STATE, 1); tick();
    sig_Coin = 1'b0; sig_Lid_Closed = 1'b1; skip_Dry = 1'b1;
    exp_o("skip.fill", O_STATE, 2); tick();
    skip_Dry = 1'b0; sig_Full = 1'b1;
    exp_o("skip.soak", O_STATE, 3); tick();
    sig_Full = 1'b0;
    adv(13);
    exp_st("skip.spin", 6, 0); tick();
    adv(1);
    exp_st("skip.spin2", 6, 2); tick();
    exp_o("skip.end", O_STATE, 0); exp_o("skip.done", O_DONE, 1); tick();

    // Fill timeout
    sig_Coin = 1'b1;
    exp_o("fto.ready", O_STATE, 1); tick();
    sig_Coin = 1'b0;
    exp_st("fto.fill", 2, 0); tick();
    adv(18);
    exp_st("fto.fill19", 2, 19); tick();
    exp_o("fto.state", O_STATE, 8); exp_o("fto.fault", O_FAULT, 1);
    exp_o("fto.code", O_CODE, 1); exp_o("fto.water", O_WATER, 0); tick();
    exp_o("fto.hold", O_STATE, 8); tick();
    sig_Lid_Closed = 1'b0; sig_Fault_Clear = 1'b1;
    exp_o("fclr.state", O_STATE, 1); exp_o("fclr.fault", O_FAULT, 0);
    exp_o("fclr.code", O_CODE, 1); exp_o("fclr.cret", O_CRET, 0); tick();
    sig_Fault_Clear = 1'b0;
    exp_o("fclr.code_hold", O_CODE, 1); exp_o("fclr.ready", O_STATE, 1); tick();

    // Lid pause in WASH
    sig_Lid_Closed = 1'b1;
    exp_st("pau.fill", 2, 0); exp_o("pau.fill.code", O_CODE, 0); tick();
    sig_Full = 1'b1;
    exp_o("pau.soak", O_STATE, 3); tick();
    sig_Full = 1'b0;
    adv(2);
    exp_st("pau.wash", 4, 0); tick();
    adv(1);
    exp_st("pau.wash2", 4, 2); tick();
    sig_Lid_Closed = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_st("pau.held", 4, 2); exp_o("pau.paused", O_PAUSED, 1);
      exp_o("pau.motor", O_MOTOR, 0); tick();
    end
    sig_Lid_Closed = 1'b1;
    exp_st("pau.resume", 4, 3); exp_o("pau.unpaused", O_PAUSED, 0);
    exp_o("pau.motor_on", O_MOTOR, 1); tick();
    exp_st("pau.wash4", 4, 4); tick();
    exp_st("pau.rinse", 5, 0); tick();

    // Simultaneous motor failure and imbalance in SPIN
    adv(5);
    exp_st("spf.spin", 6, 0); exp_o("spf.spin.rc", O_RINSE, 2); tick();
    sig_Motor_Failure = 1'b1; sig_Out_Of_Balance = 1'b1;
    exp_o("spf.state", O_STATE, 8); exp_o("spf.code", O_CODE, 3);
    exp_o("spf.fault", O_FAULT, 1); exp_o("spf.motor", O_MOTOR, 0); tick();
    sig_Motor_Failure = 1'b0; sig_Out_Of_Balance = 1'b0;
    sig_Lid_Closed = 1'b0; sig_Fault_Clear = 1'b1;
    exp_o("spf.ready", O_STATE, 1); exp_o("spf.rc_clr", O_RINSE, 0);
    exp_o("spf.code_hold", O_CODE, 3); tick();
    sig_Fault_Clear = 1'b0;

    // Cancel wins over a same-cycle fault in SPIN
    sig_Lid_Closed = 1'b1;
    exp_o("cf.fill", O_STATE, 2); exp_o("cf.code", O_CODE, 0); tick();
    sig_Full = 1'b1; tick(); sig_Full = 1'b0;
    adv(13);
    exp_o("cf.spin", O_STATE, 6); exp_o("cf.spin.rc", O_RINSE, 2); tick();
    sig_Cancel = 1'b1; sig_Motor_Failure = 1'b1;
    exp_o("cf.state", O_STATE, 0); exp_o("cf.cret", O_CRET, 1);
    exp_o("cf.fault", O_FAULT, 0); exp_o("cf.code0", O_CODE, 0);
    exp_o("cf.rc", O_RINSE, 0); exp_o("cf.motor", O_MOTOR, 0); tick();
    sig_Cancel = 1'b0; sig_Motor_Failure = 1'b0;
    exp_o("cf.cret_off", O_CRET, 0); exp_o("cf.start", O_STATE, 0); tick();

    // Asynchronous reset mid-RINSE
    sig_Coin = 1'b1; tick(); sig_Coin = 1'b0;
    tick();
    sig_Full = 1'b1; tick(); sig_Full = 1'b0;
    adv(8);
    adv(3);
    exp_st("ars.rinse", 5, 1); exp_o("ars.rc", O_RINSE, 1); tick();
    #2 reset = 1'b1;
    #1;
    exp_st("ars", 0, 0);
    exp_o("ars.rinse_cnt", O_RINSE, 0); exp_o("ars.water", O_WATER, 0);
    exp_o("ars.motor", O_MOTOR, 0);     exp_o("ars.paused", O_PAUSED, 0);
    exp_o("ars.cret", O_CRET, 0);       exp_o("ars.fault", O_FAULT, 0);
    exp_o("ars.code", O_CODE, 0);       exp_o("ars.done", O_DONE, 0);
    check_q();
    @(negedge clock);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
